uart_receive: RTL and testbench

- UART receiver: the downstream partner of the serial transmitter. It consumes the txd line (rxd here) and returns received bytes to the bus-side logic.
- Frame format: 8N1, LSB first, idle-high line.
- Bit timing comes from a shared baud generator, which supplies an oversampled tick enable.
- Data is presented with a receive-data-available flag plus framing and overrun status; a read strobe consumes it.

---
 rtl/uart_receive.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_receive.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receive.sv
// -----------------------------------------------------------------------------
// uart_receive
//   8N1 UART receiver (LSB first, idle-high line). Bit timing comes from an
//   external oversampled tick enable. A received byte is held in rx_data with
//   rda set, along with framing/overrun (and optionally parity) status. A
//   read_en strobe consumes the byte and clears the status flags.
//
//   Optional build macro: UART_RX_PARITY_EN
//     When defined, a parity bit (even parity) is expected between the last
//     data bit and the stop bit, and parity_err reports a mismatch.
//     When undefined, frames are 8N1 and parity_err is tied to 0.
//
// Parameters:
//   OVERSAMPLE  - rx_tick pulses per bit period (even, >= 4)
//   SYNC_STAGES - flops in the rxd synchronizer (>= 2)
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   rx_tick     in   one-clk enable pulse at OVERSAMPLE x baud rate
//   rxd         in   asynchronous serial input, idle high
//   read_en     in   consumer strobe; pops the held byte and clears status
//   rx_data     out  last received byte
//   rda         out  receive data available
//   framing_err out  stop bit sampled low on the held byte
//   overrun_err out  a byte was overwritten before being read
//   parity_err  out  parity mismatch on the held byte (0 without the macro)
// -----------------------------------------------------------------------------
module uart_receive #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_tick,
  input  logic       rxd,
  input  logic       read_en,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       framing_err,
  output logic       overrun_err,
  output logic       parity_err
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  // Last tick index of half a bit (start-bit centre) and of a full bit.
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [2:0]             bit_q, bit_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rda_q, rda_d;
  logic                   fe_q, fe_d;
  logic                   oe_q, oe_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_bit_q, par_bit_d;
  logic                   pe_q, pe_d;
`endif

  logic rxd_s;
  logic complete;

  assign rxd_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    rda_d     = rda_q;
    fe_d      = fe_q;
    oe_d      = oe_q;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
    pe_d      = pe_q;
`endif
    complete  = 1'b0;

    // rxd enters at bit 0 and emerges as rxd_s at the top bit.
    sync_d = {sync_q[SYNC_STAGES-2:0], rxd};

    // Consumer read. A completion on the same edge overrides these below,
    // so the new frame's status wins.
    if (read_en && rda_q) begin
      rda_d = 1'b0;
      fe_d  = 1'b0;
      oe_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_d  = 1'b0;
`endif
    end

    case (state_q)
      S_IDLE: begin
        // Level-detect the start bit; ticks are not counted here.
        if (!rxd_s) begin
          state_d = S_START;
          tick_d  = '0;
        end
      end

      S_START: begin
        if (rx_tick) begin
          if (tick_q == HALF_LAST) begin
            tick_d  = '0;
            bit_d   = 3'd0;
            // High at the start-bit centre means a glitch, not a frame.
            state_d = rxd_s ? S_IDLE : S_DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (rx_tick) begin
          if (tick_q == FULL_LAST) begin
            tick_d  = '0;
            // Right shift: the first (LSB) bit ends up at bit 0 after eight.
            shift_d = {rxd_s, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (rx_tick) begin
          if (tick_q == FULL_LAST) begin
            tick_d    = '0;
            par_bit_d = rxd_s;
            state_d   = S_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`endif

      S_STOP: begin
        if (rx_tick) begin
          if (tick_q == FULL_LAST) begin
            tick_d   = '0;
            complete = 1'b1;
            // A low stop bit may be a break; wait for the line to recover
            // so a held-low line cannot look like a stream of start bits.
            state_d  = rxd_s ? S_IDLE : S_BREAK;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      S_BREAK: begin
        if (rxd_s) begin
          state_d = S_IDLE;
          tick_d  = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
      end
    endcase

    if (complete) begin
      rx_data_d = shift_q;
      rda_d     = 1'b1;
      fe_d      = ~rxd_s;
      // Overrun only when the held byte is lost unread; a simultaneous read
      // has already cleared oe_d above.
      if (rda_q && !read_en) begin
        oe_d = 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      pe_d = ^{shift_q, par_bit_q};
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= 3'd0;
      sync_q    <= '1;
      shift_q   <= 8'h00;
      rx_data_q <= 8'h00;
      rda_q     <= 1'b0;
      fe_q      <= 1'b0;
      oe_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      sync_q    <= sync_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      rda_q     <= rda_d;
      fe_q      <= fe_d;
      oe_q      <= oe_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= par_bit_d;
      pe_q      <= pe_d;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rda         = rda_q;
  assign framing_err = fe_q;
  assign overrun_err = oe_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = pe_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receive.sv
// -----------------------------------------------------------------------------
// tb_uart_receive
//   Directed bench for uart_receive (OVERSAMPLE=16, rx_tick every 4 clks).
//   Expected frame results are queued when a frame is sent and popped when
//   the receiver presents the byte.
// -----------------------------------------------------------------------------
module tb_uart_receive;

  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = OS * TICK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int L_EXP = (8 + 10 * OS) * TICK_DIV;
`else
  localparam int L_EXP = (8 + 9 * OS) * TICK_DIV;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_tick;
  logic       rxd = 1'b1;
  logic       read_en = 1'b0;
  logic [7:0] rx_data;
  logic       rda;
  logic       framing_err;
  logic       overrun_err;
  logic       parity_err;

  logic [1:0] tick_div = 2'd0;

  always #5 clk = ~clk;

  always @(posedge clk) tick_div <= tick_div + 2'd1;
  assign rx_tick = (tick_div == 2'd3);

  uart_receive #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_tick     (rx_tick),
    .rxd         (rxd),
    .read_en     (read_en),
    .rx_data     (rx_data),
    .rda         (rda),
    .framing_err (framing_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       oe;
    logic       pe;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic fe, input logic oe, input logic pe);
    exp_t e;
    e.data = d;
    e.fe   = fe;
    e.oe   = oe;
`ifdef UART_RX_PARITY_EN
    e.pe   = pe;
`else
    e.pe   = 1'b0 & pe;
`endif
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    check({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_rda"},  32'(rda),         32'd1);
      check({tag, "_data"}, 32'(rx_data),     32'(e.data));
      check({tag, "_fe"},   32'(framing_err), 32'(e.fe));
      check({tag, "_oe"},   32'(overrun_err), 32'(e.oe));
      check({tag, "_pe"},   32'(parity_err),  32'(e.pe));
      $display("frame %s: data=%02h fe=%0b oe=%0b pe=%0b", tag, rx_data, framing_err, overrun_err, parity_err);
    end
  endtask

  // Wait for a negedge where the next rx_tick is four edges away, so the
  // frame-to-tick phase is identical for every frame.
  task automatic align();
    @(negedge clk);
    while (tick_div != 2'd0) @(negedge clk);
  endtask

  // Drives a full frame starting now; leaves rxd at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_good);
    rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^d) ^ ~par_good;
    repeat (BIT_CLKS) @(negedge clk);
`endif
    rxd = stop_b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic do_read(input string tag, input logic [7:0] held);
    @(negedge clk);
    read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
    check({tag, "_rda_clr"},  32'(rda),         32'd0);
    check({tag, "_fe_clr"},   32'(framing_err), 32'd0);
    check({tag, "_oe_clr"},   32'(overrun_err), 32'd0);
    check({tag, "_pe_clr"},   32'(parity_err),  32'd0);
    check({tag, "_hold"},     32'(rx_data),     32'(held));
    $display("read %s: rda=%0b data=%02h", tag, rda, rx_data);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data", 32'(rx_data),     32'h00);
    check("rst_rda",  32'(rda),         32'd0);
    check("rst_fe",   32'(framing_err), 32'd0);
    check("rst_oe",   32'(overrun_err), 32'd0);
    check("rst_pe",   32'(parity_err),  32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // 0xA5 with latency measurement from the start-bit drive
    push_exp(8'hA5, 1'b0, 1'b0, 1'b0);
    align();
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        lat = 0;
        while (!rda && lat < 2000) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("latency", 32'(lat), 32'(L_EXP));
    $display("latency: %0d clks", lat);
    check_out("a5");
    do_read("a5", 8'hA5);

    // False start: low for 4 ticks only
    align();
    rxd = 1'b0;
    repeat (4 * TICK_DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (BIT_CLKS * 11) @(negedge clk);
    check("false_start_rda", 32'(rda), 32'd0);
    $display("false start: rda=%0b", rda);
    push_exp(8'h3C, 1'b0, 1'b0, 1'b0);
    align();
    send_frame(8'h3C, 1'b1, 1'b1);
    check_out("3c");
    do_read("3c", 8'h3C);

    // Framing error, then a long held-low line must not retrigger
    push_exp(8'h3C, 1'b1, 1'b0, 1'b0);
    align();
    send_frame(8'h3C, 1'b0, 1'b1);
    check_out("3c_fe");
    do_read("3c_fe", 8'h3C);
    repeat (170 * TICK_DIV) @(negedge clk);
    check("break_rda", 32'(rda), 32'd0);
    $display("break hold: rda=%0b", rda);
    rxd = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);

    // Overrun: two bytes without a read
    push_exp(8'h11, 1'b0, 1'b0, 1'b0);
    align();
    send_frame(8'h11, 1'b1, 1'b1);
    check_out("ovr_11");
    push_exp(8'h22, 1'b0, 1'b1, 1'b0);
    align();
    send_frame(8'h22, 1'b1, 1'b1);
    check_out("ovr_22");
    do_read("ovr_22", 8'h22);

    // Read on the exact completion edge of the second byte
    push_exp(8'h11, 1'b0, 1'b0, 1'b0);
    align();
    send_frame(8'h11, 1'b1, 1'b1);
    check_out("sim_11");
    push_exp(8'h22, 1'b0, 1'b0, 1'b0);
    align();
    fork
      send_frame(8'h22, 1'b1, 1'b1);
      begin
        repeat (L_EXP - 1) @(negedge clk);
        read_en = 1'b1;
        @(negedge clk);
        read_en = 1'b0;
        check_out("sim_22");
      end
    join

    // Asynchronous reset mid-DATA of 0xFF while rda is still set
    align();
    fork
      send_frame(8'hFF, 1'b1, 1'b1);
      begin
        repeat (4 * BIT_CLKS) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", 32'(rx_data),     32'h00);
        check("mid_rst_rda",  32'(rda),         32'd0);
        check("mid_rst_fe",   32'(framing_err), 32'd0);
        check("mid_rst_oe",   32'(overrun_err), 32'd0);
        check("mid_rst_pe",   32'(parity_err),  32'd0);
        $display("mid-frame reset: rda=%0b data=%02h", rda, rx_data);
        sb.delete();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (BIT_CLKS) @(negedge clk);
    check("post_rst_rda", 32'(rda), 32'd0);
    push_exp(8'h5A, 1'b0, 1'b0, 1'b0);
    align();
    send_frame(8'h5A, 1'b1, 1'b1);
    check_out("5a");
    do_read("5a", 8'h5A);

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit
    push_exp(8'h96, 1'b0, 1'b0, 1'b1);
    align();
    send_frame(8'h96, 1'b1, 1'b0);
    check_out("par_bad");
    do_read("par_bad", 8'h96);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish, required finish before limit");
    $fatal(1, "timeout");
  end

endmodule
